// File: rtl/iter_counter.sv
// Iteration counter for the ALU's multi-cycle sequential operations
// (shift-add multiply, restoring divide). Counts LIMIT+1 enabled cycles,
// either up or down, with a level done flag, a START/ACK handshake, ABORT
// and an optional auto-reload mode that emits a one-cycle wrap pulse.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for START; count holds (or is cleared by ABORT)
//   S_RUN  | advancing count on each ENABLE until the terminal value
//   S_DONE | run finished; done=1, count holds final value until ACK/START
module iter_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             down_i,
  input  logic             auto_reload_i,
  input  logic             enable_i,
  input  logic             ack_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             last_o,
  output logic             done_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic             at_term;

  // Terminal value depends on the direction latched at START, not the live input.
  assign at_term = dir_q ? (count_q == ZERO) : (count_q == limit_q);

  // Next-state decode: ABORT beats START/ACK, which beat ENABLE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    dir_d    = dir_q;
    reload_d = reload_q;
    wrap_d   = 1'b0;

    if (abort_i) begin
      state_d = S_IDLE;
      count_d = ZERO;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            limit_d  = limit_i;
            dir_d    = down_i;
            reload_d = auto_reload_i;
            count_d  = down_i ? limit_i : ZERO;
            state_d  = S_RUN;
          end else if (state_q == S_DONE && ack_i) begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (enable_i) begin
            if (!at_term) begin
              count_d = dir_q ? (count_q - ONE) : (count_q + ONE);
            end else if (reload_q) begin
              count_d = dir_q ? limit_q : ZERO;
              wrap_d  = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = ZERO;
        end
      endcase
    end

    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      count_q  <= ZERO;
      limit_q  <= ZERO;
      dir_q    <= 1'b0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = (state_q == S_RUN);
  assign last_o  = (state_q == S_RUN) && at_term;
  assign done_o  = done_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_iter_counter.sv
// Bench for iter_counter: a fixed vector table, directed multi-cycle
// sequences and randomized traffic against a run-index reference model.
module tb_iter_counter;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst, start, down, auto_rl, enable, ack, abort;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         busy, last, done, wrap;

  int checks   = 0;
  int failures = 0;

  iter_counter #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .limit_i(limit),
    .down_i(down), .auto_reload_i(auto_rl), .enable_i(enable),
    .ack_i(ack), .abort_i(abort),
    .count_o(count), .busy_o(busy), .last_o(last), .done_o(done), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: phase (0 idle, 1 run, 2 done) and k = number of enabled
  // iterations completed in the current pass; count is derived from k.
  int ph = 0, k = 0, mlim = 0, idle_cnt = 0;
  bit mdir = 0, mrel = 0, mwrap = 0;

  function automatic int m_count();
    if (ph == 0) return idle_cnt;
    return mdir ? (mlim - k) : k;
  endfunction

  function automatic void model_step(bit r, bit s, int l, bit d, bit a, bit e, bit ak, bit ab);
    mwrap = 0;
    if (r) begin
      ph = 0; k = 0; idle_cnt = 0; mlim = 0; mdir = 0; mrel = 0;
    end else if (ab) begin
      ph = 0; idle_cnt = 0;
    end else if ((ph == 0 || ph == 2) && s) begin
      ph = 1; k = 0; mlim = l; mdir = d; mrel = a;
    end else if (ph == 2 && ak) begin
      idle_cnt = m_count();
      ph = 0;
    end else if (ph == 1 && e) begin
      if (k == mlim) begin
        if (mrel) begin k = 0; mwrap = 1; end
        else ph = 2;
      end else k++;
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int c, bit b, bit l, bit dn, bit w);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".busy"},  int'(busy),  int'(b));
    chk({tag, ".last"},  int'(last),  int'(l));
    chk({tag, ".done"},  int'(done),  int'(dn));
    chk({tag, ".wrap"},  int'(wrap),  int'(w));
  endtask

  // Apply inputs at negedge, advance the model at the edge, sample #1 after.
  task automatic cyc(bit r, bit s, int l, bit d, bit a, bit e, bit ak, bit ab);
    @(negedge clk);
    rst = r; start = s; limit = W'(l); down = d; auto_rl = a;
    enable = e; ack = ak; abort = ab;
    @(posedge clk);
    model_step(r, s, l, d, a, e, ak, ab);
    #1;
  endtask

  task automatic cyc_m(string tag, bit r, bit s, int l, bit d, bit a, bit e, bit ak, bit ab);
    cyc(r, s, l, d, a, e, ak, ab);
    chk_all(tag, m_count(), ph == 1, (ph == 1) && (k == mlim), ph == 2, mwrap);
  endtask

  typedef struct {
    bit rst, start; int lim; bit dn, ar, en, ack, ab;
    int e_cnt; bit e_busy, e_last, e_done, e_wrap;
  } vec_t;

  vec_t tbl[22];

  initial begin
    rst = 1; start = 0; limit = '0; down = 0; auto_rl = 0; enable = 0; ack = 0; abort = 0;

    //           rst st lim dn ar en ak ab   cnt bsy lst dn wr
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0};
    tbl[4]  = '{0, 1, 3, 1, 0, 0, 1, 0,   3, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 0, 0,   2, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 2, 0, 1, 1, 0, 0,   0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 1, 0, 0,   2, 1, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 1, 0, 0,   2, 1, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 1, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 1, 0, 0,   1, 1, 1, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 0};
    tbl[20] = '{0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0};
    tbl[21] = '{0, 1, 5, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0};

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].rst, tbl[i].start, tbl[i].lim, tbl[i].dn, tbl[i].ar,
          tbl[i].en, tbl[i].ack, tbl[i].ab);
      chk_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_busy,
              tbl[i].e_last, tbl[i].e_done, tbl[i].e_wrap);
    end

    // Full up-count of LIMIT=7, done held until ACK.
    cyc_m("t1.start", 0, 1, 7, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc_m("t1.run", 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc_m("t1.hold", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc_m("t1.ack", 0, 0, 0, 0, 0, 0, 1, 0);

    // Down-count LIMIT=5 with ENABLE toggling; LIMIT input changes mid-run.
    cyc_m("t2.start", 0, 1, 5, 1, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc_m("t2.run", 0, 0, 2, 0, 1, (i % 2) == 0, 0, 0);
    cyc_m("t2.ack", 0, 0, 0, 0, 0, 0, 1, 0);

    // Auto-reload LIMIT=2: wraps, never done.
    cyc_m("t3.start", 0, 1, 2, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc_m("t3.run", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc_m("t3.abort", 0, 0, 0, 0, 0, 1, 0, 1);

    // Abort at count=3 of LIMIT=7.
    cyc_m("t4.start", 0, 1, 7, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc_m("t4.run", 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t4.pre_abort_count", int'(count), 3);
    cyc_m("t4.abort", 0, 0, 0, 0, 0, 1, 0, 1);
    cyc_m("t4.idle", 0, 0, 0, 0, 0, 1, 0, 0);

    // START ignored in RUN, then reset mid-run at count=4.
    cyc_m("t5.start", 0, 1, 6, 0, 0, 1, 0, 0);
    cyc_m("t5.run", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc_m("t5.restart", 0, 1, 1, 1, 1, 1, 0, 0);
    cyc_m("t5.run", 0, 0, 0, 0, 0, 1, 0, 0);
    cyc_m("t5.run", 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t5.pre_rst_count", int'(count), 4);
    cyc_m("t5.rst", 1, 0, 0, 0, 0, 1, 0, 0);
    chk_all("t5.rst_const", 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc_m("rnd",
            $urandom_range(0, 199) == 0,
            $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
